// File: rtl/mem_access_unit.sv
// Bridges the $mem register to a byte-wide data memory: loads write back via RegMemWrite, stores send memRead.
// Optional wait-counter timeout abort is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  store,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] memRead,
   output logic [DATA_WIDTH-1:0] memWrite,
   output logic                  RegMemWrite,
   output logic                  stall,
   output logic                  error,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
   state_t state;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..255");
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt;
`endif

   // Stall covers the request cycle itself, before the FSM has left IDLE.
   assign stall = (state != IDLE) || load || store;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         memWrite    <= '0;
         RegMemWrite <= 1'b0;
         error       <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         RegMemWrite <= 1'b0;
         error       <= 1'b0;
         case (state)
            IDLE: begin
               if (load || store) begin
                  mem_addr <= addr;
                  mem_req  <= 1'b1;
                  state    <= REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  // Store has priority when both requests are present.
                  if (store) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= memRead;
                  end else begin
                     mem_we <= 1'b0;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_we) begin
                     state <= IDLE;
                  end else begin
                     memWrite    <= mem_rdata;
                     RegMemWrite <= 1'b1;
                     state       <= WB;
                  end
               end
`ifdef MEM_ACCESS_TIMEOUT_EN
               else if (wait_cnt == LIMIT) begin
                  mem_req <= 1'b0;
                  error   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; covers both builds of MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_unit;

   logic       clock = 1'b0;
   logic       reset_n, load, store, mem_ack;
   logic [7:0] addr, memRead, mem_rdata;
   logic [7:0] memWrite, mem_addr, mem_wdata;
   logic       RegMemWrite, stall, error, mem_req, mem_we;

   int errors = 0;
   int checks = 0;

   // Per-transaction activity counts, sampled on the falling edge.
   bit mon = 1'b0;
   int stall_n, req_n, rmw_n, err_n, err_req_n;
   logic [7:0] last_mw;

   mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
      .memRead(memRead), .memWrite(memWrite), .RegMemWrite(RegMemWrite),
      .stall(stall), .error(error), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mon) begin
         stall_n   += int'(stall);
         req_n     += int'(mem_req);
         rmw_n     += int'(RegMemWrite);
         err_n     += int'(error);
         err_req_n += int'(error & mem_req);
         if (RegMemWrite) last_mw = memWrite;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      stall_n = 0; req_n = 0; rmw_n = 0; err_n = 0; err_req_n = 0;
      last_mw = 8'h00;
   endtask

   // One access: request held for the accept edge only, ack on REQ cycle ack_at (0 = never).
   task automatic access(input string tag, input logic ld, input logic st,
                         input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rd,
                         input int ncyc, input int ack_at, input int trail);
      load = ld; store = st; addr = a; memRead = wd;
      mon = 1'b1;
      tick();
      load = 1'b0; store = 1'b0; addr = ~a; memRead = ~wd;
      for (int i = 1; i <= ncyc; i++) begin
         chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
         chk({tag, " mem_we"}, 32'(mem_we), 32'(st));
         chk({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
         if (st) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wd));
         if (i == ack_at) begin
            mem_ack = 1'b1; mem_rdata = rd;
         end
         tick();
         mem_ack = 1'b0; mem_rdata = 8'hFF;
      end
      for (int i = 0; i < trail; i++) tick();
      mon = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; load = 1'b0; store = 1'b0; addr = 8'h00; memRead = 8'h00;
      mem_ack = 1'b0; mem_rdata = 8'h00;
      tick(); tick();
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst memWrite", 32'(memWrite), 32'd0);
      chk("rst RegMemWrite", 32'(RegMemWrite), 32'd0);
      chk("rst error", 32'(error), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      store = 1'b1; #1;
      chk("rst stall with store", 32'(stall), 32'd1);
      store = 1'b0;
      reset_n = 1'b1;
      tick();

      // Load 0x2A returning 0x5C, ack on first REQ cycle.
      clr();
      access("ld1", 1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 1, 1, 2);
      chk("ld1 stall cycles", 32'(stall_n), 32'd3);
      chk("ld1 req cycles", 32'(req_n), 32'd1);
      chk("ld1 rmw pulses", 32'(rmw_n), 32'd1);
      chk("ld1 memWrite", 32'(last_mw), 32'h5C);
      chk("ld1 memWrite held", 32'(memWrite), 32'h5C);
      chk("ld1 error", 32'(err_n), 32'd0);

      // Store 0xA7 to 0x10, ack on 4th REQ cycle.
      clr();
      access("st1", 1'b0, 1'b1, 8'h10, 8'hA7, 8'h00, 4, 4, 2);
      chk("st1 stall cycles", 32'(stall_n), 32'd5);
      chk("st1 req cycles", 32'(req_n), 32'd4);
      chk("st1 rmw pulses", 32'(rmw_n), 32'd0);
      chk("st1 memWrite untouched", 32'(memWrite), 32'h5C);

      // Load and store together: store-only.
      clr();
      access("both", 1'b1, 1'b1, 8'h03, 8'h3C, 8'h77, 1, 1, 3);
      chk("both stall cycles", 32'(stall_n), 32'd2);
      chk("both rmw pulses", 32'(rmw_n), 32'd0);
      chk("both memWrite untouched", 32'(memWrite), 32'h5C);

`ifdef MEM_ACCESS_TIMEOUT_EN
      // Load with no ack: abort after 4 REQ cycles.
      clr();
      access("to", 1'b1, 1'b0, 8'h44, 8'h00, 8'h00, 4, 0, 2);
      chk("to req cycles", 32'(req_n), 32'd4);
      chk("to error pulses", 32'(err_n), 32'd1);
      chk("to error with req", 32'(err_req_n), 32'd0);
      chk("to rmw pulses", 32'(rmw_n), 32'd0);
      chk("to stall cycles", 32'(stall_n), 32'd5);
      chk("to stall low", 32'(stall), 32'd0);
      // Ack on the limit cycle wins.
      clr();
      access("to_ack", 1'b1, 1'b0, 8'h45, 8'h00, 8'hC3, 4, 4, 2);
      chk("to_ack req cycles", 32'(req_n), 32'd4);
      chk("to_ack error pulses", 32'(err_n), 32'd0);
      chk("to_ack rmw pulses", 32'(rmw_n), 32'd1);
      chk("to_ack memWrite", 32'(last_mw), 32'hC3);
`else
      // No timeout: REQ waits indefinitely.
      clr();
      access("wait", 1'b1, 1'b0, 8'h44, 8'h00, 8'hC3, 21, 21, 2);
      chk("wait req cycles", 32'(req_n), 32'd21);
      chk("wait error pulses", 32'(err_n), 32'd0);
      chk("wait rmw pulses", 32'(rmw_n), 32'd1);
      chk("wait memWrite", 32'(last_mw), 32'hC3);
`endif

      // Reset during REQ of a load, then a late ack.
      load = 1'b1; addr = 8'h55;
      tick();
      load = 1'b0;
      chk("mr mem_req before reset", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mr mem_req", 32'(mem_req), 32'd0);
      chk("mr mem_addr", 32'(mem_addr), 32'd0);
      chk("mr memWrite", 32'(memWrite), 32'd0);
      chk("mr RegMemWrite", 32'(RegMemWrite), 32'd0);
      chk("mr stall", 32'(stall), 32'd0);
      clr();
      mon = 1'b1;
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      tick();
      mem_ack = 1'b0;
      tick(); tick();
      mon = 1'b0;
      chk("mr late ack req", 32'(req_n), 32'd0);
      chk("mr late ack rmw", 32'(rmw_n), 32'd0);
      chk("mr late ack stall", 32'(stall_n), 32'd0);
      chk("mr late ack memWrite", 32'(memWrite), 32'd0);
      clr();
      access("mr_ld", 1'b1, 1'b0, 8'h2B, 8'h00, 8'h91, 1, 1, 2);
      chk("mr_ld rmw pulses", 32'(rmw_n), 32'd1);
      chk("mr_ld memWrite", 32'(last_mw), 32'h91);

      // Back-to-back store then load.
      clr();
      access("b2b_st", 1'b0, 1'b1, 8'h20, 8'h6D, 8'h00, 1, 1, 0);
      access("b2b_ld", 1'b1, 1'b0, 8'h21, 8'h00, 8'hB4, 1, 1, 2);
      chk("b2b stall cycles", 32'(stall_n), 32'd5);
      chk("b2b req cycles", 32'(req_n), 32'd2);
      chk("b2b rmw pulses", 32'(rmw_n), 32'd1);
      chk("b2b memWrite", 32'(last_mw), 32'hB4);
      chk("b2b stall low", 32'(stall), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bridges the NanoRisc `$mem` register to an external byte-wide data memory. On a load it reads `mem[addr]` and writes the byte into `$mem` through the register bank's `memWrite`/`RegMemWrite` port. On a store it sends the current `$mem` value (`memRead`) to `mem[addr]`. It sits between the control unit and the data memory, and stalls the core until each access completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 8: data width; matches register width.
- `TIMEOUT_CYCLES`, 15: maximum REQ cycles before abort. Range 1..255.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load`  in  1  control: load request `mem[addr]` -> `$mem`.
- `store`  in  1  control: store request `$mem` -> `mem[addr]`.
- `addr`  in  ADDR_WIDTH  access address.
- `memRead`  in  DATA_WIDTH  current `$mem` value from the register bank.
- `memWrite`  out  DATA_WIDTH  load data to the register bank.
- `RegMemWrite`  out  1  one-cycle strobe that writes `memWrite` into `$mem`.
- `stall`  out  1  core hold.
- `error`  out  1  one-cycle timeout pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_WIDTH  latched address.
- `mem_wdata`  out  DATA_WIDTH  latched store data.
- `mem_rdata`  in  DATA_WIDTH  read data; valid when `mem_ack` is high.
- `mem_ack`  in  1  one-cycle completion from memory.

## Operation
FSM states: IDLE, REQ, WB.

IDLE:
- On `load` or `store`, latch `addr` into `mem_addr`.
- On `store`, latch `memRead` into `mem_wdata` and set `mem_we`=1.
- On `load`, set `mem_we`=0.
- Go to REQ.
- If `load` and `store` are both high, store wins and the load is dropped.
- `mem_ack` is ignored in IDLE.

REQ:
- `mem_req`=1. `mem_addr`, `mem_we` and `mem_wdata` are held stable.
- Store + `mem_ack`: go to IDLE.
- Load + `mem_ack`: capture `mem_rdata` into `memWrite`, go to WB.
- No ack: increment the wait counter. When the counter reaches TIMEOUT_CYCLES, pulse `error`, go to IDLE, and do not write back.
- If `mem_ack` arrives on the same cycle the limit is hit, the ack wins.

WB:
- `RegMemWrite`=1 for exactly one cycle, then go to IDLE.

Outputs:
- `stall` = (state != IDLE) | (state == IDLE & (load | store)). It is combinational, so the request cycle itself stalls.
- `memWrite` holds its last captured value. Only `RegMemWrite` qualifies it.

Reset:
- With `reset_n` low at a rising edge: state IDLE, counter 0.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `memWrite`, `RegMemWrite` and `error` all go to 0.
- `stall` is 0 unless `load` or `store` is high.
- Reset mid-access abandons the access. No `RegMemWrite` is issued. A late `mem_ack` arriving after reset is ignored (the block is in IDLE).

## Timing
Request accepted at edge 0.

- `mem_req` is high from cycle 1.
- If `mem_ack` is high in cycle k (k ≥ 1):
  - Store: IDLE at k+1. `stall` is low in cycle k+1 provided no new request is present.
  - Load: `RegMemWrite` high in cycle k+1; IDLE at k+2.
- Best case, with ack in the first REQ cycle:
  - Load: 3 stall cycles (request cycle, REQ, WB).
  - Store: 2 stall cycles (request cycle, REQ).
- Timeout: `error` is high in the cycle after the TIMEOUT_CYCLES-th REQ cycle without ack, with the block in IDLE. `mem_req` is low in that same cycle.
- Back-to-back: a request present in the first IDLE cycle after completion is accepted immediately. There are no dead cycles beyond IDLE.
- The requester must hold `load`/`store` and `addr` until `stall` falls. The block samples them only in IDLE.

## Configuration
`MEM_ACCESS_TIMEOUT_EN`:
- Defined: the wait counter and timeout abort are compiled in, as described above.
- Undefined: no counter. REQ waits indefinitely for `mem_ack`, `error` is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Load, addr=0x2A, memory returns 0x5C with ack on the first REQ cycle -> `mem_req` high 1 cycle with `mem_we`=0 and `mem_addr`=0x2A; `RegMemWrite` pulses once with `memWrite`=0x5C; `stall` high exactly 3 cycles.
- Store, `memRead`=0xA7, addr=0x10, ack after 4 REQ cycles -> `mem_we`=1 and `mem_wdata`=0xA7 stable for 4 cycles; no `RegMemWrite`; `stall` high 5 cycles.
- `load` and `store` together, addr=0x03 -> store-only transaction; `mem_we`=1; `RegMemWrite` never asserts.
- With `MEM_ACCESS_TIMEOUT_EN` and TIMEOUT_CYCLES=4, load with no ack -> `mem_req` high 4 cycles; `error` pulses 1 cycle; no `RegMemWrite`; `stall` falls. Repeat with ack on the 4th REQ cycle -> normal completion, `error` stays 0.
- `reset_n` low during REQ of a load, then `mem_ack` arrives after reset -> all outputs 0; no `RegMemWrite`; the next load completes normally.
- Back-to-back store then load, each acked on the first REQ cycle -> the load is accepted in the first IDLE cycle after the store and finishes with the correct `memWrite`.
